// File: rtl/ac_motor_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ac_motor_ramp_sequencer
// Purpose  : Soft-start / soft-stop sequencer for the AC motor control stage.
//            Slews POWER toward TARGET by STEP_SIZE every STEP_DIV clocks,
//            holds it in RUN, ramps down (or cuts) on disable, forces zero
//            power on FAULT, and passes the mode/delay/U-min word through
//            only while idle.
// Macro    : AC_MOTOR_SOFT_STOP_EN - when defined, dropping ENABLE in
//            RAMP/RUN ramps POWER down through STOP; when undefined, POWER
//            is cut and the sequencer returns straight to IDLE.
// Ports    : CLK, RESET (async, active-high)
//            ENABLE, FAULT, FAULT_CLR     - run / fault-stop / fault-ack
//            TARGET[RESOLUTION_BITS]      - requested power setpoint
//            CFG_MOD_DELAY_UMIN[16]       - requested config word
//            POWER[RESOLUTION_BITS]       - power word to motor stage
//            MOD_DELAY_UMIN[16]           - config word to motor stage
//            STATE[3], AT_TARGET, BUSY    - status
// Revision : 1.0 - initial release
// ============================================================================
module ac_motor_ramp_sequencer #(
    parameter int RESOLUTION_BITS = 12,
    parameter int STEP_DIV        = 1000,
    parameter int STEP_SIZE       = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       ENABLE,
    input  logic                       FAULT,
    input  logic                       FAULT_CLR,
    input  logic [RESOLUTION_BITS-1:0] TARGET,
    input  logic [15:0]                CFG_MOD_DELAY_UMIN,
    output logic [RESOLUTION_BITS-1:0] POWER,
    output logic [15:0]                MOD_DELAY_UMIN,
    output logic [2:0]                 STATE,
    output logic                       AT_TARGET,
    output logic                       BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam int                         c_presc_w    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_presc_w-1:0]       c_presc_last = c_presc_w'(STEP_DIV - 1);
    localparam logic [RESOLUTION_BITS:0]   c_step       = (RESOLUTION_BITS + 1)'(STEP_SIZE);
    localparam logic [15:0]                c_cfg_reset  = 16'hFF00;

    state_t                       state_q, state_d;
    logic [RESOLUTION_BITS-1:0]   power_q, power_d;
    logic [15:0]                  cfg_q, cfg_d;
    logic [c_presc_w-1:0]         presc_q, presc_d;
    logic                         at_target_q, busy_q;

    // Step arithmetic is done one bit wider so overflow/underflow is visible
    // and the result can be clamped instead of wrapping.
    logic [RESOLUTION_BITS:0]     w_up, w_dn;
    logic [RESOLUTION_BITS-1:0]   w_up_sat, w_dn_sat;
    logic                         w_tick;

    assign w_tick   = (presc_q == c_presc_last);
    assign w_up     = {1'b0, power_q} + c_step;
    assign w_dn     = {1'b0, power_q} - c_step;
    assign w_up_sat = (w_up > {1'b0, TARGET}) ? TARGET : w_up[RESOLUTION_BITS-1:0];
    // w_dn MSB set means the subtraction borrowed below zero.
    assign w_dn_sat = (w_dn[RESOLUTION_BITS] || (w_dn[RESOLUTION_BITS-1:0] < TARGET))
                      ? TARGET : w_dn[RESOLUTION_BITS-1:0];
`ifdef AC_MOTOR_SOFT_STOP_EN
    logic [RESOLUTION_BITS-1:0]   w_dn_floor;
    assign w_dn_floor = w_dn[RESOLUTION_BITS] ? '0 : w_dn[RESOLUTION_BITS-1:0];
`endif

    always_comb begin
        state_d = state_q;
        power_d = power_q;
        cfg_d   = cfg_q;
        // Prescaler is zero outside counting, so every RAMP/STOP entry
        // starts a fresh step period.
        presc_d = '0;

        if (state_q == ST_IDLE) begin
            cfg_d = CFG_MOD_DELAY_UMIN;
        end

        if (FAULT) begin
            state_d = ST_FAULT;
            power_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    power_d = '0;
                    if (ENABLE) begin
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    // Disable wins over a coincident tick: no step taken.
                    if (!ENABLE) begin
`ifdef AC_MOTOR_SOFT_STOP_EN
                        state_d = ST_STOP;
`else
                        state_d = ST_IDLE;
                        power_d = '0;
`endif
                    end else if (power_q == TARGET) begin
                        state_d = ST_RUN;
                    end else if (w_tick) begin
                        power_d = (power_q < TARGET) ? w_up_sat : w_dn_sat;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!ENABLE) begin
`ifdef AC_MOTOR_SOFT_STOP_EN
                        state_d = ST_STOP;
`else
                        state_d = ST_IDLE;
                        power_d = '0;
`endif
                    end else if (power_q != TARGET) begin
                        state_d = ST_RAMP;
                    end
                end
`ifdef AC_MOTOR_SOFT_STOP_EN
                ST_STOP: begin
                    if (ENABLE) begin
                        state_d = ST_RAMP;
                    end else if (power_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (w_tick) begin
                        power_d = w_dn_floor;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
`endif
                ST_FAULT: begin
                    power_d = '0;
                    if (FAULT_CLR && !ENABLE) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    // Illegal encodings fall into the safe state.
                    state_d = ST_FAULT;
                    power_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            power_q     <= '0;
            cfg_q       <= c_cfg_reset;
            presc_q     <= '0;
            at_target_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            power_q     <= power_d;
            cfg_q       <= cfg_d;
            presc_q     <= presc_d;
            at_target_q <= (state_d == ST_RUN);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign POWER          = power_q;
    assign MOD_DELAY_UMIN = cfg_q;
    assign STATE          = state_q;
    assign AT_TARGET      = at_target_q;
    assign BUSY           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ac_motor_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ac_motor_ramp_sequencer
// Purpose  : Self-checking bench. Three sequencers with different step
//            settings share the control inputs (each has its own TARGET);
//            a behavioural model predicts every output every cycle, and
//            directed literal checks pin the model on known sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ac_motor_ramp_sequencer;

    localparam int RB = 8;
    localparam int N  = 3;

    logic            clk;
    logic            rst;
    logic            en;
    logic            flt;
    logic            clr;
    logic [15:0]     cfg;
    logic [RB-1:0]   tgt [N];
    logic [RB-1:0]   pwr [N];
    logic [15:0]     mdu [N];
    logic [2:0]      sta [N];
    logic            att [N];
    logic            bsy [N];

    int checks = 0;
    int errors = 0;

    // instance k: STEP_DIV / STEP_SIZE
    function automatic int div_of(int k);
        return (k == 2) ? 1 : 4;
    endfunction
    function automatic int size_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 5 : 3);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        ac_motor_ramp_sequencer #(
            .RESOLUTION_BITS(RB),
            .STEP_DIV       ((g == 2) ? 1 : 4),
            .STEP_SIZE      ((g == 0) ? 1 : ((g == 1) ? 5 : 3))
        ) u_dut (
            .CLK               (clk),
            .RESET             (rst),
            .ENABLE            (en),
            .FAULT             (flt),
            .FAULT_CLR         (clr),
            .TARGET            (tgt[g]),
            .CFG_MOD_DELAY_UMIN(cfg),
            .POWER             (pwr[g]),
            .MOD_DELAY_UMIN    (mdu[g]),
            .STATE             (sta[g]),
            .AT_TARGET         (att[g]),
            .BUSY              (bsy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: 0 idle, 1 ramp, 2 run, 3 stop, 4 fault.
    // ------------------------------------------------------------------
    int          m_st  [N];
    int          m_pw  [N];
    int          m_cnt [N];
    logic [15:0] m_cfg [N];

    function automatic int approach(int cur, int goal, int step);
        if (cur < goal) return (cur + step > goal) ? goal : cur + step;
        if (cur > goal) return (cur - step < goal) ? goal : cur - step;
        return cur;
    endfunction

    task automatic model_reset(int k);
        m_st[k]  = 0;
        m_pw[k]  = 0;
        m_cnt[k] = 0;
        m_cfg[k] = 16'hFF00;
    endtask

    task automatic model_step(int k, bit e, bit f, bit c, int t, logic [15:0] cf);
        bit tick;
        tick = (m_cnt[k] == div_of(k) - 1);
        if (m_st[k] == 0) m_cfg[k] = cf;
        if (f) begin
            m_st[k] = 4; m_pw[k] = 0; m_cnt[k] = 0;
        end else if (m_st[k] == 0) begin
            m_pw[k] = 0;
            if (e) begin m_st[k] = 1; m_cnt[k] = 0; end
        end else if ((m_st[k] == 1 || m_st[k] == 2) && !e) begin
`ifdef AC_MOTOR_SOFT_STOP_EN
            m_st[k] = 3; m_cnt[k] = 0;
`else
            m_st[k] = 0; m_pw[k] = 0; m_cnt[k] = 0;
`endif
        end else if (m_st[k] == 1) begin
            if (m_pw[k] == t) begin
                m_st[k] = 2; m_cnt[k] = 0;
            end else if (tick) begin
                m_pw[k] = approach(m_pw[k], t, size_of(k)); m_cnt[k] = 0;
            end else begin
                m_cnt[k]++;
            end
        end else if (m_st[k] == 2) begin
            if (m_pw[k] != t) begin m_st[k] = 1; m_cnt[k] = 0; end
        end else if (m_st[k] == 3) begin
            if (e) begin
                m_st[k] = 1; m_cnt[k] = 0;
            end else if (m_pw[k] == 0) begin
                m_st[k] = 0;
            end else if (tick) begin
                m_pw[k] = approach(m_pw[k], 0, size_of(k)); m_cnt[k] = 0;
            end else begin
                m_cnt[k]++;
            end
        end else begin
            m_pw[k] = 0;
            if (c && !e) m_st[k] = 0;
        end
    endtask

    // Compare process: update the model on each edge, check just after.
    initial begin
        for (int k = 0; k < N; k++) model_reset(k);
        forever begin
            @(posedge clk);
            for (int k = 0; k < N; k++) begin
                if (rst) model_reset(k);
                else model_step(k, en, flt, clr, int'(tgt[k]), cfg);
            end
            #1;
            for (int k = 0; k < N; k++) begin
                check($sformatf("model power[%0d]", k), 32'(pwr[k]), m_pw[k]);
                check($sformatf("model state[%0d]", k), 32'(sta[k]), m_st[k]);
                check($sformatf("model cfg[%0d]", k), 32'(mdu[k]), 32'(m_cfg[k]));
                check($sformatf("model at_target[%0d]", k), 32'(att[k]), 32'(m_st[k] == 2));
                check($sformatf("model busy[%0d]", k), 32'(bsy[k]), 32'(m_st[k] != 0));
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus with directed literal checks, then random traffic.
    initial begin
        bit found;
        rst = 1'b1; en = 1'b0; flt = 1'b0; clr = 1'b0; cfg = 16'h1234;
        for (int k = 0; k < N; k++) tgt[k] = '0;
        cyc(2);
        check("reset power", 32'(pwr[0]), 0);
        check("reset cfg", 32'(mdu[0]), 32'h0000FF00);
        check("reset state", 32'(sta[0]), 0);
        check("reset busy", 32'(bsy[0]), 0);

        rst = 1'b0;
        cyc(1);
        check("idle cfg load", 32'(mdu[0]), 32'h00001234);

        // Fine (A) and coarse (B) ramps started together.
        tgt[0] = 8'd3; tgt[1] = 8'd12; tgt[2] = 8'd10; en = 1'b1;
        cyc(1);
        check("ramp entry state", 32'(sta[0]), 1);
        check("ramp entry power", 32'(pwr[0]), 0);
        cyc(3);
        check("fine pre-tick power", 32'(pwr[0]), 0);
        cyc(1);
        check("fine step1", 32'(pwr[0]), 1);
        check("coarse step1", 32'(pwr[1]), 5);
        cyc(4);
        check("fine step2", 32'(pwr[0]), 2);
        check("coarse step2", 32'(pwr[1]), 10);
        cyc(4);
        check("fine step3", 32'(pwr[0]), 3);
        check("coarse clamp", 32'(pwr[1]), 12);
        check("ramp still", 32'(sta[0]), 1);
        cyc(1);
        check("run state", 32'(sta[0]), 2);
        check("run at_target", 32'(att[0]), 1);

        // Config is frozen outside IDLE.
        cfg = 16'h8000;
        cyc(3);
        check("cfg frozen A", 32'(mdu[0]), 32'h00001234);
        check("cfg frozen B", 32'(mdu[1]), 32'h00001234);

        // Retarget B downward from RUN.
        tgt[1] = 8'd7;
        cyc(1);
        check("retarget ramp", 32'(sta[1]), 1);
        cyc(4);
        check("retarget power", 32'(pwr[1]), 7);
        cyc(1);
        check("retarget run", 32'(sta[1]), 2);

        // Disable from RUN at POWER=3.
        en = 1'b0;
        cyc(1);
`ifdef AC_MOTOR_SOFT_STOP_EN
        check("stop entry", 32'(sta[0]), 3);
        cyc(4);
        check("stop step1", 32'(pwr[0]), 2);
        cyc(4);
        check("stop step2", 32'(pwr[0]), 1);
        cyc(4);
        check("stop step3", 32'(pwr[0]), 0);
        cyc(1);
        check("stop idle", 32'(sta[0]), 0);
`else
        check("cut power", 32'(pwr[0]), 0);
        check("cut idle", 32'(sta[0]), 0);
`endif
        cyc(20);
        check("cfg reload", 32'(mdu[0]), 32'h00008000);

        // Fault at POWER=10 during a ramp.
        tgt[0] = 8'd20; en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc(1);
            if (pwr[0] == 8'd10) found = 1'b1;
        end
        check("reach power 10", 32'(found), 1);
        flt = 1'b1;
        cyc(1);
        flt = 1'b0;
        check("fault power", 32'(pwr[0]), 0);
        check("fault state", 32'(sta[0]), 4);
        clr = 1'b1;
        cyc(2);
        check("fault clr ignored", 32'(sta[0]), 4);
        en = 1'b0;
        cyc(1);
        check("fault cleared", 32'(sta[0]), 0);
        clr = 1'b0;

        // Asynchronous reset mid-ramp.
        en = 1'b1;
        cyc(10);
        #2 rst = 1'b1;
        #1;
        check("async power", 32'(pwr[0]), 0);
        check("async cfg", 32'(mdu[0]), 32'h0000FF00);
        check("async state", 32'(sta[0]), 0);
        check("async busy", 32'(bsy[0]), 0);
        cyc(2);
        rst = 1'b0;

        // Random traffic, checked by the model every cycle.
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            flt = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 3) == 0);
            cfg = 16'($urandom);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 29) == 0) begin
                    tgt[k] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(240, 255))
                                                          : 8'($urandom_range(0, 40));
                end
            end
        end
        rst = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ac_motor_ramp_sequencer.md
# ac_motor_ramp_sequencer

Soft-start/soft-stop sequencer that drives the power and mode/delay/U-min configuration inputs of the AC motor control stage. It ramps the power word toward a requested setpoint at a programmable slew rate, holds it, and ramps it down (or cuts it) on disable. It forces zero power on fault. It sits between the host register interface and the motor control block. The configuration word is accepted only while the motor is idle.

## Interface
Parameters:
- `RESOLUTION_BITS`, 12: width of the power word.
- `STEP_DIV`, 1000: clock cycles per ramp step. Must be ≥1.
- `STEP_SIZE`, 1: power LSBs moved per ramp step. Must be ≥1 and <2^RESOLUTION_BITS.

Ports:
- `CLK` in 1: single clock.
- `RESET` in 1: asynchronous, active-high reset.
- `ENABLE` in 1: run request, level-sensitive.
- `FAULT` in 1: fault stop request, level-sensitive, highest priority.
- `FAULT_CLR` in 1: fault acknowledge.
- `TARGET` in RESOLUTION_BITS: requested power setpoint.
- `CFG_MOD_DELAY_UMIN` in 16: requested config word. Bit 15 is modulation, 14:8 is delay, 7:0 is U-min.
- `POWER` out RESOLUTION_BITS: power word to the motor control stage.
- `MOD_DELAY_UMIN` out 16: config word to the motor control stage.
- `STATE` out 3: current state encoding.
- `AT_TARGET` out 1: high in RUN.
- `BUSY` out 1: high in any state other than IDLE.

## Operation
- States and encodings:
  - IDLE=0, RAMP=1, RUN=2, STOP=3, FAULT=4.
  - Encodings 5–7 are illegal and recover to FAULT on the next edge.
- Reset values:
  - STATE=IDLE, POWER=0, MOD_DELAY_UMIN=16'hFF00 (modulation=1, maximum delay, U-min=0), AT_TARGET=0, BUSY=0.
  - Prescaler counter=0.
- Priority: `FAULT` high in any state → FAULT. POWER=0 on the next edge; the prescaler clears.
- IDLE:
  - POWER=0.
  - MOD_DELAY_UMIN ← CFG_MOD_DELAY_UMIN every cycle.
  - ENABLE=1 and FAULT=0 → RAMP.
- RAMP:
  - The prescaler counts 0..STEP_DIV-1. A tick occurs at STEP_DIV-1, then the count wraps to 0.
  - On a tick: if POWER<TARGET, POWER ← min(POWER+STEP_SIZE, TARGET). If POWER>TARGET, POWER ← max(POWER−STEP_SIZE, TARGET).
  - POWER==TARGET (checked every cycle) → RUN.
  - ENABLE=0 → STOP.
- RUN:
  - POWER is held.
  - TARGET≠POWER → RAMP, with the prescaler restarting at 0.
  - ENABLE=0 → STOP.
- STOP:
  - On a tick, POWER ← max(POWER−STEP_SIZE, 0).
  - POWER==0 → IDLE.
  - ENABLE=1 → RAMP, continuing from the current POWER.
- FAULT:
  - POWER=0.
  - FAULT=0, FAULT_CLR=1 and ENABLE=0 → IDLE.
  - FAULT_CLR with ENABLE=1 is ignored.
- MOD_DELAY_UMIN is frozen in every state except IDLE.
- Arithmetic:
  - Add/subtract in RESOLUTION_BITS+1 bits, then saturate.
  - POWER never wraps and never passes TARGET or 0.
- The prescaler resets to 0 on every entry to RAMP or STOP.

## Timing
- All outputs are registered; one-cycle latency from input to output.
- IDLE→RAMP: STATE=1 on the first edge with ENABLE high. The first POWER change is STEP_DIV edges later.
- Ramp 0→T: ceil(T/STEP_SIZE)·STEP_DIV edges after entering RAMP. RUN follows one edge after POWER==TARGET.
- STEP_DIV=1: a tick on every cycle in RAMP/STOP.
- FAULT→POWER=0: one edge, regardless of state or prescaler phase.
- RESET mid-ramp: outputs go to reset values immediately (asynchronously). The sequence resumes from IDLE after RESET deasserts.
- Simultaneous events:
  - ENABLE falling on the same edge as a RAMP tick: the STOP transition wins and no increment occurs.
  - FAULT overrides all other events.

## Configuration
- Macro: `AC_MOTOR_SOFT_STOP_EN`.
- Defined: ENABLE=0 in RAMP/RUN → STOP, which ramps down as described above.
- Undefined: ENABLE=0 in RAMP/RUN → IDLE on the next edge with POWER=0. The STOP state is unreachable; encoding 3 is treated as illegal.

## Test plan
- Reset: assert RESET mid-ramp → POWER=0, MOD_DELAY_UMIN=16'hFF00, STATE=0, BUSY=0, all asynchronously.
- Fine ramp: STEP_DIV=4, STEP_SIZE=1, TARGET=3, ENABLE=1 → POWER=1,2,3 at 4,8,12 edges after RAMP entry; STATE=2 and AT_TARGET=1 one edge later.
- Coarse ramp without overshoot: STEP_SIZE=5, TARGET=12 → POWER=5,10,12. Then TARGET=7 in RUN → RAMP, POWER=7 one tick later, then RUN.
- Fault handling: FAULT pulse at POWER=10 during RAMP → POWER=0 and STATE=4 next edge. FAULT_CLR with ENABLE=1 → stays in FAULT. FAULT_CLR with ENABLE=0 → IDLE.
- Stop with `AC_MOTOR_SOFT_STOP_EN` defined: RUN at POWER=3, ENABLE=0 → POWER=2,1,0 per tick, then IDLE. With the macro undefined: POWER=0 and STATE=0 next edge.
- Config freeze: CFG_MOD_DELAY_UMIN=16'h1234 in IDLE → MOD_DELAY_UMIN=16'h1234 next edge. Change it to 16'h8000 in RUN → output stays 16'h1234 until IDLE is re-entered.
